// File: rtl/pipe_elastic.sv
// Three-stage elastic arithmetic pipeline with valid/ready flow control and occupancy count.
// Optional overflow flag aligned with f when PIPE_ELASTIC_OVF_EN is defined.
module pipe_elastic #(
   parameter int N = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   input  logic [N-1:0] d,
   input  logic [1:0]   mode,
   output logic [N-1:0] f,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [1:0]   count
`ifdef PIPE_ELASTIC_OVF_EN
   ,
   output logic         ovf
`endif
);

   // Sum/product widths grow only when the overflow bits are needed.
`ifdef PIPE_ELASTIC_OVF_EN
   localparam int CW = N + 1;
   localparam int PW = 2 * N;
`else
   localparam int CW = N;
   localparam int PW = N;
`endif

   logic         r_v1, r_v2, r_v3;
   logic [N-1:0] r_x1, r_x2, r_d1;
   logic [1:0]   r_m1;
   logic [N-1:0] r_x3, r_d2;
   logic [1:0]   r_m2;
   logic [N-1:0] r_f;

   logic          w_adv1, w_adv2, w_adv3, w_accept;
   logic [CW-1:0] w_sab;
   logic [CW-1:0] w_s2;
   logic [PW-1:0] w_p2, w_p3;
   logic [N-1:0]  w_x3;
   logic [N-1:0]  w_f;

   // Ready chain runs back from the consumer; a stage moves when its successor frees up.
   assign w_adv3   = r_v3 & out_ready;
   assign w_adv2   = r_v2 & (~r_v3 | w_adv3);
   assign w_adv1   = r_v1 & (~r_v2 | w_adv2);
   assign in_ready = ~r_v1 | w_adv1;
   assign w_accept = in_valid & in_ready;

   assign w_sab = CW'(a) + CW'(b);
   assign w_s2  = CW'(r_x1) + CW'(r_x2);
   assign w_p2  = PW'(r_x1) * PW'(r_x2);
   assign w_p3  = PW'(r_x3) * PW'(r_d2);

   always_comb begin
      w_x3 = w_s2[N-1:0];
      case (r_m1)
         2'b01:   w_x3 = r_x1 - r_x2;
         2'b10:   w_x3 = w_p2[N-1:0];
         default: w_x3 = w_s2[N-1:0];
      endcase
   end

   assign w_f = r_m2[1] ? r_x3 : w_p3[N-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
         r_x1 <= '0;
         r_x2 <= '0;
         r_d1 <= '0;
         r_m1 <= '0;
         r_x3 <= '0;
         r_d2 <= '0;
         r_m2 <= '0;
         r_f  <= '0;
      end else begin
         r_v1 <= w_accept | (r_v1 & ~w_adv1);
         r_v2 <= w_adv1 | (r_v2 & ~w_adv2);
         r_v3 <= w_adv2 | (r_v3 & ~w_adv3);
         if (w_accept) begin
            r_x1 <= w_sab[N-1:0];
            r_x2 <= c - d;
            r_d1 <= d;
            r_m1 <= mode;
         end
         if (w_adv1) begin
            r_x3 <= w_x3;
            r_d2 <= r_d1;
            r_m2 <= r_m1;
         end
         if (w_adv2) r_f <= w_f;
      end
   end

   assign f         = r_f;
   assign out_valid = r_v3;
   assign count     = 2'(r_v1) + 2'(r_v2) + 2'(r_v3);

`ifdef PIPE_ELASTIC_OVF_EN
   logic r_o1, r_o2, r_o3;
   logic w_ovf1, w_ovf2, w_ovf3;

   assign w_ovf1 = w_sab[CW-1] | (c < d);

   always_comb begin
      w_ovf2 = r_o1 | w_s2[CW-1];
      case (r_m1)
         2'b01:   w_ovf2 = r_o1 | (r_x1 < r_x2);
         2'b10:   w_ovf2 = r_o1 | (|w_p2[PW-1:N]);
         default: w_ovf2 = r_o1 | w_s2[CW-1];
      endcase
   end

   assign w_ovf3 = r_o2 | (~r_m2[1] & (|w_p3[PW-1:N]));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_o1 <= 1'b0;
         r_o2 <= 1'b0;
         r_o3 <= 1'b0;
      end else begin
         if (w_accept) r_o1 <= w_ovf1;
         if (w_adv1)   r_o2 <= w_ovf2;
         if (w_adv2)   r_o3 <= w_ovf3;
      end
   end

   assign ovf = r_o3;
`endif

endmodule

// File: tb/tb_pipe_elastic.sv
// Directed and randomized checks of pipe_elastic (N=10) with in-order result scoreboard.
module tb_pipe_elastic;
   localparam int N = 10;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready;
   logic [N-1:0] a, b, c, d, f;
   logic [1:0]   mode, count;
`ifdef PIPE_ELASTIC_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int failures = 0;

   logic [N-1:0] va[8], vb[8], vc[8], vd[8], ef[8];
   logic [1:0]   vm[8];
   logic         eo[8];
   int first_cyc, last_cyc, ready_drop;

   pipe_elastic #(.N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d), .mode(mode),
      .f(f), .out_valid(out_valid), .out_ready(out_ready), .count(count)
`ifdef PIPE_ELASTIC_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_vec(input int i, input int av, input int bv, input int cv, input int dv,
                          input int mv, input int fv, input int ov);
      va[i] = N'(av); vb[i] = N'(bv); vc[i] = N'(cv); vd[i] = N'(dv);
      vm[i] = 2'(mv); ef[i] = N'(fv); eo[i] = ov[0];
   endtask

   function automatic logic [N:0] ref_res(input int ai, input int bi, input int ci,
                                          input int di, input int mi);
      int s, x1, x2, t, x3, p, fr;
      logic o;
      s  = ai + bi;
      o  = (s > 1023) || (ci < di);
      x1 = s % 1024;
      x2 = (ci - di + 1024) % 1024;
      case (mi)
         1: begin o = o || (x1 < x2); t = (x1 - x2 + 1024) % 1024; end
         2: begin t = x1 * x2; o = o || (t > 1023); end
         default: begin t = x1 + x2; o = o || (t > 1023); end
      endcase
      x3 = t % 1024;
      if (mi < 2) begin
         p  = x3 * di;
         o  = o || (p > 1023);
         fr = p % 1024;
      end else begin
         fr = x3;
      end
      return {o, N'(fr)};
   endfunction

   task automatic check_result(input string tag, input logic [N-1:0] exp_f, input logic exp_o);
      chk(tag, 32'(f), 32'(exp_f));
`ifdef PIPE_ELASTIC_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
`endif
   endtask

   // Streams vectors [sent0..n-1] with out_ready=1 and checks results 0..n-1 in order.
   task automatic stream(input int n, input int sent0);
      int sent = sent0;
      int got  = 0;
      int cyc  = 0;
      first_cyc = -1; last_cyc = -1; ready_drop = 0;
      out_ready = 1'b1;
      while (got < n && cyc < 50) begin
         if (sent < n) begin
            in_valid = 1'b1;
            a = va[sent]; b = vb[sent]; c = vc[sent]; d = vd[sent]; mode = vm[sent];
         end else in_valid = 1'b0;
         #1;
         if (sent < n && !in_ready) ready_drop++;
         if (out_valid) begin
            check_result($sformatf("stream_res%0d", got), ef[got], eo[got]);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            got++;
         end
         if (in_valid && in_ready) sent++;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      chk("stream_count", 32'(got), 32'(n));
   endtask

   initial begin
      int sent, got, cyc;
      logic [N:0] q[$];
      logic [N:0] r;
      logic hold;
      logic [N-1:0] hf;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; c = '0; d = '0; mode = '0;
      tick(); tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_f", 32'(f), 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 1);

      // Single transaction latency
      a = 10; b = 12; c = 6; d = 2; mode = 2'b00; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat_e1_valid", 32'(out_valid), 0);
      chk("lat_e1_count", 32'(count), 1);
      tick();
      chk("lat_e2_valid", 32'(out_valid), 0);
      tick();
      chk("lat_e3_valid", 32'(out_valid), 1);
      check_result("lat_e3_f", 10'd52, 1'b0);
      tick();
      chk("lat_drain_valid", 32'(out_valid), 0);
      chk("lat_drain_count", 32'(count), 0);

      // Back-to-back throughput
      set_vec(0, 10, 12, 6, 2, 1, 36, 0);
      set_vec(1, 10, 12, 6, 2, 2, 88, 0);
      set_vec(2, 10, 12, 6, 2, 3, 26, 0);
      set_vec(3, 20, 11, 1, 4, 0, 112, 1);
      stream(4, 0);
      chk("b2b_span", 32'(last_cyc - first_cyc), 3);
      chk("b2b_ready_drop", 32'(ready_drop), 0);

      // Backpressure fill, then release
      set_vec(0, 1, 2, 3, 1, 0, 5, 0);
      set_vec(1, 5, 5, 2, 3, 1, 33, 1);
      set_vec(2, 3, 4, 5, 6, 2, 1017, 1);
      set_vec(3, 100, 200, 50, 25, 3, 325, 0);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a = va[k]; b = vb[k]; c = vc[k]; d = vd[k]; mode = vm[k]; in_valid = 1'b1;
         #1;
         chk($sformatf("bp_ready%0d", k), 32'(in_ready), 1);
         tick();
      end
      chk("bp_count_full", 32'(count), 3);
      chk("bp_ready_full", 32'(in_ready), 0);
      a = va[3]; b = vb[3]; c = vc[3]; d = vd[3]; mode = vm[3];
      tick(); tick();
      chk("bp_hold_count", 32'(count), 3);
      chk("bp_hold_valid", 32'(out_valid), 1);
      check_result("bp_hold_f", 10'd5, 1'b0);
      chk("bp_hold_ready", 32'(in_ready), 0);
      out_ready = 1'b1;
      #1;
      chk("full_drain_ready", 32'(in_ready), 1);
      stream(4, 3);
      chk("bp_end_count", 32'(count), 0);

      // Reset with two in flight
      a = 10; b = 12; c = 6; d = 2; mode = 2'b00; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      chk("mid_rst_pre_count", 32'(count), 2);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_count", 32'(count), 0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("mid_rst_stale%0d", k), 32'(out_valid), 0);
      end

      // Modulo wrap
      set_vec(0, 1023, 1, 0, 0, 3, 0, 1);
      set_vec(1, 1, 1, 1, 1, 0, 2, 0);
      stream(2, 0);

      // Random valid/ready traffic against the reference model
      sent = 0; got = 0; cyc = 0; hold = 1'b0; hf = '0;
      while (got < 1000 && cyc < 20000) begin
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a = N'($urandom_range(0, 1023)); b = N'($urandom_range(0, 1023));
         c = N'($urandom_range(0, 1023)); d = N'($urandom_range(0, 1023));
         mode = 2'($urandom_range(0, 3));
         #1;
         hold = out_valid && !out_ready;
         hf   = f;
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("rand_spurious", 1, 0);
            else begin
               r = q.pop_front();
               check_result($sformatf("rand_res%0d", got), r[N-1:0], r[N]);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_res(int'(a), int'(b), int'(c), int'(d), int'(mode)));
            sent++;
         end
         tick();
         cyc++;
         if (hold) chk("rand_stall_stable", {21'd0, out_valid, f}, {21'd0, 1'b1, hf});
      end
      in_valid = 1'b0;
      chk("rand_count", 32'(got), 1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
